serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_subtractor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, result after WIDTH+1 cycles.
// Optional signed-overflow flag and port enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    cnt;
    logic             borrow;

    logic             ai;
    logic             bi;
    logic             d_bit;
    logic             br_next;
    logic             last_bit;
    logic [WIDTH-1:0] diff_shift;

    // Operand registers shift right, so the bit under work is always bit 0.
    assign ai         = a_reg[0];
    assign bi         = b_reg[0];
    assign d_bit      = ai ^ bi ^ borrow;
    assign br_next    = (~ai & bi) | (~(ai ^ bi) & borrow);
    assign last_bit   = (cnt == CW'(WIDTH - 1));
    assign diff_shift = {d_bit, diff[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        diff   <= '0;
                        bout   <= 1'b0;
                        zero   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                        ovf    <= 1'b0;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                        busy   <= 1'b1;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_reg  <= a_reg >> 1;
                    b_reg  <= b_reg >> 1;
                    borrow <= br_next;
                    diff   <= diff_shift;
                    if (last_bit) begin
                        // Flags are taken from the completed word so they line up with done.
                        bout  <= br_next;
                        zero  <= (diff_shift == '0);
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (a_msb != b_msb) && (diff_shift[WIDTH-1] != a_msb);
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized bench for serial_subtractor (WIDTH=32) against a plain-arithmetic model.
// Checks ovf too when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One subtraction; scramble changes a/b after acceptance, interfere pulses start mid-SHIFT.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit scramble, input bit interfere);
        logic [W-1:0] exp_diff;
        logic         exp_bout;
        logic [W-1:0] held;
        int           cycles;
        exp_diff = x - y;
        exp_bout = (x < y);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        check("busy_after_accept", busy, 1'b1);
        start = 1'b0;
        if (scramble) begin
            a = $urandom;
            b = $urandom;
        end
        cycles = 0;
        while (!done && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (interfere && cycles == 5) begin
                start = 1'b1;
                a     = $urandom;
                b     = $urandom;
            end
            if (interfere && cycles == 12) start = 1'b0;
        end
        check("latency", cycles, W);
        check("done", done, 1'b1);
        check("busy_in_done", busy, 1'b0);
        check("diff", diff, exp_diff);
        check("bout", bout, exp_bout);
        check("zero", zero, (exp_diff == '0));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", ovf, (x[W-1] != y[W-1]) && (exp_diff[W-1] != x[W-1]));
`endif
        held = diff;
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 1'b0);
        check("idle_not_busy", busy, 1'b0);
        check("diff_hold", diff, held);
        $display("op a=%08h b=%08h diff=%08h bout=%0d zero=%0d cycles=%0d", x, y, held, bout, zero, cycles);
    endtask

    initial begin
        int dones;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, '0);
        check("rst_bout", bout, 1'b0);
        check("rst_zero", zero, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd5, 32'd3, 1'b0, 1'b0);
        run_op(32'd3, 32'd5, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'd1, 1'b0, 1'b0);
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run_op(32'd0, 32'd1, 1'b0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'h1234_5678, 32'h0BAD_F00D, 1'b0, 1'b1);

        // No spurious completion after an interfered operation.
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("no_extra_done", dones, 0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : $urandom;
            run_op(ra, rb, i[0], i[1]);
        end

        // Reset in the middle of SHIFT must clear outputs at once and cancel the result.
        @(negedge clk);
        start = 1'b1;
        a     = 32'hFFFF_0000;
        b     = 32'h0000_1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_diff", diff, '0);
        check("abort_bout", bout, 1'b0);
        check("abort_zero", zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check("abort_no_done", dones, 0);
        run_op(32'd5, 32'd3, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
